birth_seq_detector: RTL
=======================

Name: birth_seq_detector

Overview:
- Receiver side of the birth-digit generator: consumes a stream of 4-bit BCD digits and detects the 8-digit sequence 1,9,9,7,0,7,2,8.
- Emits a one-cycle match pulse and a running match count.
- Sits downstream of any digit source, such as the generator or a keypad/UART digit decoder, on a simple valid-qualified digit bus.

Parameters:
- CNT_W, 8, width of the saturating match counter.
- TIMEOUT, 16, idle cycles allowed between digits mid-sequence (used only when the optional feature is compiled in; legal range 1..2^16-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_digit is presented this cycle.
- in_digit  input  4  BCD digit; legal values 0..9.
- progress  output  3  number of sequence digits matched so far (0..7).
- match  output  1  one-cycle pulse when the full sequence completes.
- bad_digit  output  1  one-cycle pulse when an accepted digit is greater than 9.
- match_cnt  output  CNT_W  total matches, saturating at all-ones.

Behaviour:
- Single clock domain; reset is synchronous and active-high. All outputs are registered.
- Reset values: progress=0, match=0, bad_digit=0, match_cnt=0.
- A digit is consumed only on a cycle with in_valid=1. Cycles with in_valid=0 hold state, and match/bad_digit drop to 0.
- The FSM has states S0..S7, where Sk means k digits are matched; progress reflects k. Expected digit in Sk is SEQ[k], with SEQ = {1,9,9,7,0,7,2,8}.
- Transition on a valid digit d:
  - d>9: next state S0, bad_digit=1 on the following cycle, no match.
  - d==SEQ[k] and k<7: next state S(k+1).
  - d==SEQ[7] in S7: next state S0, match=1 on the following cycle, match_cnt increments (holds at 2^CNT_W-1).
  - Mismatch with d==1: next state S1, because the only self-overlap prefix of the pattern is "1".
  - Mismatch otherwise: next state S0.
- Latency: match asserts exactly 1 cycle after the cycle carrying the final digit 8.
- Back-to-back sequences with no idle cycles detect each match. Example: 1997072819970728 produces two pulses 8 cycles apart.
- Reset mid-sequence returns the FSM to S0 on the next edge. Any partial progress is discarded and no match is produced.
- rst has priority over in_valid in the same cycle.
- If match_cnt is saturated, match still pulses.

Optional Feature:
- Macro: BIRTH_DET_TIMEOUT_EN.
- Defined: a 16-bit idle counter clears on every valid digit and increments on every idle cycle while in S1..S7. When it reaches TIMEOUT, the FSM returns to S0 on the next edge and the counter clears. No output pulse is produced on timeout. In S0 the counter stays at 0.
- Not defined: no idle counter exists, and partial progress holds indefinitely across idle cycles.

Decomposition:
- Package birth_pkg:
  - SEQ_LEN=8
  - digit_t (4-bit)
  - state_t enum S0..S7
  - constant SEQ digit array {1,9,9,7,0,7,2,8}
  - MAX_DIGIT=9
- Sub-module birth_digit_rom: combinational index[2:0] to digit[3:0] lookup of SEQ. The detector instantiates it with index=progress to obtain the expected digit.
- The generator can share the same sub-module.

Test Plan:
- Reset, then stream 1,9,9,7,0,7,2,8 with in_valid=1 every cycle -> progress steps 1..7, then 0; match=1 one cycle after the digit 8; match_cnt=1.
- Stream 1,9,1,9,9,7,0,7,2,8 -> mismatch on the second 1 goes to S1 (not S0); exactly one match; match_cnt=1.
- Stream 1,9,9,7,0,7,2,8,1,9,9,7,0,7,2,8 back-to-back -> two match pulses 8 cycles apart; match_cnt=2.
- Stream 1,9,9,12 -> bad_digit=1 one cycle after the 12; progress=0; no match.
- Stream 1,9,9,7 then assert rst for 1 cycle, then 0,7,2,8 -> no match; progress=0 after reset; match_cnt=0.
- Run with BIRTH_DET_TIMEOUT_EN and TIMEOUT=4:
  - 1,9,9, then 4 idle cycles, then 7,0,7,2,8 -> progress returns to 0 after the idle cycles; no match.
  - Same stream with 3 idle cycles -> match=1.

Source files
------------

// File: rtl/birth_pkg.sv
// birth_pkg: shared types and constants for the birth-digit sequence blocks.
//   SEQ_LEN   - number of digits in the target sequence (8)
//   MAX_DIGIT - largest legal BCD digit (9)
//   IDLE_W    - width of the optional mid-sequence idle counter
//   digit_t   - 4-bit BCD digit
//   state_t   - detector state Sk, k = digits matched so far
//   SEQ       - the target sequence 1,9,9,7,0,7,2,8
package birth_pkg;

  localparam int unsigned SEQ_LEN   = 8;
  localparam int unsigned MAX_DIGIT = 9;
  localparam int unsigned IDLE_W    = 16;

  typedef logic [3:0] digit_t;

  typedef enum logic [2:0] {
    S0, S1, S2, S3, S4, S5, S6, S7
  } state_t;

  localparam digit_t SEQ [SEQ_LEN] = '{4'd1, 4'd9, 4'd9, 4'd7, 4'd0, 4'd7, 4'd2, 4'd8};

  // True for legal BCD values 0..9.
  function automatic logic is_bcd(input digit_t d);
    return d <= digit_t'(MAX_DIGIT);
  endfunction

endpackage

// File: rtl/birth_seq_detector_if.sv
// birth_seq_detector_if: valid-qualified digit bus between a digit source
// (generator, keypad or UART decoder) and the sequence detector.
//   in_valid - in_digit carries a digit this cycle
//   in_digit - BCD digit, legal values 0..9
// Modports: master = digit source, slave = digit consumer.
interface birth_seq_detector_if;
  import birth_pkg::*;

  logic   in_valid;
  digit_t in_digit;

  modport master (
    output in_valid,
    output in_digit
  );

  modport slave (
    input in_valid,
    input in_digit
  );

endinterface

// File: rtl/birth_digit_rom.sv
// birth_digit_rom: combinational lookup of the target sequence.
//   index - position in the sequence (0..7)
//   digit - SEQ[index]
// Shared by the generator and the detector so both agree on the pattern.
module birth_digit_rom
  import birth_pkg::*;
(
  input  logic [2:0] index,
  output digit_t     digit
);

  always_comb begin
    digit = SEQ[index];
  end

endmodule

// File: rtl/birth_seq_detector.sv
// birth_seq_detector: detects the digit sequence 1,9,9,7,0,7,2,8 on a
// valid-qualified BCD digit bus.
//   clk       - system clock, rising edge
//   rst       - synchronous, active-high reset (priority over the bus)
//   bus       - digit bus (slave modport): in_valid, in_digit
//   progress  - digits of the sequence matched so far (0..7)
//   match     - one-cycle pulse the cycle after the final 8 is accepted
//   bad_digit - one-cycle pulse the cycle after a digit > 9 is accepted
//   match_cnt - total matches, saturating at all-ones
// Optional build macro BIRTH_DET_TIMEOUT_EN: partial progress is discarded
// after TIMEOUT consecutive idle cycles in S1..S7. Without it, progress
// holds indefinitely across idle cycles.
module birth_seq_detector
  import birth_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  birth_seq_detector_if.slave    bus,
  output logic [2:0]             progress,
  output logic                   match,
  output logic                   bad_digit,
  output logic [CNT_W-1:0]       match_cnt
);

  state_t           state_q, state_d;
  digit_t           expected;
  logic             digit_ok;
  logic             digit_hit;
  logic             timeout_hit;
  logic             match_q, match_d;
  logic             bad_q, bad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expected digit for the current state.
  birth_digit_rom u_rom (
    .index (state_q),
    .digit (expected)
  );

  assign digit_ok  = is_bcd(bus.in_digit);
  assign digit_hit = bus.in_valid && digit_ok && (bus.in_digit == expected);

`ifdef BIRTH_DET_TIMEOUT_EN
  logic [IDLE_W-1:0] idle_q, idle_d;

  // The timeout fires on the edge that ends the TIMEOUT-th consecutive idle
  // cycle, so exactly TIMEOUT idle cycles are enough to lose progress.
  always_comb begin
    idle_d      = idle_q;
    timeout_hit = 1'b0;
    if (state_q == S0 || bus.in_valid) begin
      idle_d = '0;
    end else if (idle_q + IDLE_W'(1) >= IDLE_W'(TIMEOUT)) begin
      idle_d      = '0;
      timeout_hit = 1'b1;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic [IDLE_W-1:0] unused_timeout;

  assign unused_timeout = IDLE_W'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (bus.in_valid) begin
      if (!digit_ok) begin
        state_d = S0;
      end else if (bus.in_digit == expected) begin
        state_d = (state_q == S7) ? S0 : state_t'(state_q + 3'd1);
      end else if (bus.in_digit == 4'd1) begin
        // "1" is the only prefix of the pattern that is also a suffix of a
        // partial match, so a stray 1 restarts at S1 rather than S0.
        state_d = S1;
      end else begin
        state_d = S0;
      end
    end else if (timeout_hit) begin
      state_d = S0;
    end
  end

  // Output logic: next values of the registered pulses and counter.
  always_comb begin
    match_d = digit_hit && (state_q == S7);
    bad_d   = bus.in_valid && !digit_ok;
    cnt_d   = cnt_q;
    if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      match_q <= match_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
    end
  end

  assign progress  = state_q;
  assign match     = match_q;
  assign bad_digit = bad_q;
  assign match_cnt = cnt_q;

endmodule
